mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-master arbiter and sequencer in front of the single-port simulated memory, which is read via DPI with 1-cycle registered rvalid and written at the clock edge. Shares the memory between the IFU (read-only) and the LSU (read/write). Requests use valid/ready on both request and response channels. One outstanding transaction at a time, round-robin arbitration, and a read timeout with an error response.

Parameters:
ADDR_W, 33, memory address width
DATA_W, 64, data width
TIMEOUT, 16, max cycles in WAIT before an error response (>=2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
if_req_valid  in  1  IFU read request
if_req_ready  out  1  IFU request accepted
if_req_addr  in  ADDR_W  IFU read address
if_resp_valid  out  1  IFU response valid
if_resp_ready  in  1  IFU response taken
if_resp_data  out  DATA_W  IFU read data
if_resp_err  out  1  IFU timeout error
ls_req_valid  in  1  LSU request
ls_req_ready  out  1  LSU request accepted
ls_req_wen  in  1  1=write, 0=read
ls_req_addr  in  ADDR_W  LSU address
ls_req_wdata  in  DATA_W  LSU write data
ls_req_wmask  in  DATA_W/8  LSU byte mask
ls_resp_valid  out  1  LSU response valid (read data or write ack)
ls_resp_ready  in  1  LSU response taken
ls_resp_data  out  DATA_W  LSU read data (0 for writes)
ls_resp_err  out  1  LSU timeout error
mem_ren  out  1  memory read enable
mem_wen  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wmask  out  DATA_W/8  memory write mask
mem_rdata  in  DATA_W  memory read data
mem_rvalid  in  1  memory read data valid

Behaviour:
- Reset (reset=0, async): state=IDLE; rr_last=LSU; timeout counter=0; request/response latches=0. All outputs 0 except if_req_ready/ls_req_ready, which follow the IDLE rule below.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready is combinational and is 1 only for the granted master.
  - Grant: the sole valid master. If both are valid, the master not equal to rr_last.
  - On handshake: latch master id, addr, wen (IFU: wen=0), wdata, wmask; set rr_last=granted; go to ISSUE.
  - No valid request: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_addr/mem_wdata/mem_wmask are driven from the latch.
  - mem_ren=~wen and mem_wen=wen. Both strobes are 0 in every other state; mem_addr/mem_wdata/mem_wmask hold the latched values.
  - Read: go to WAIT, counter=0.
  - Write: set resp_data=0, err=0; go to RESP.
- WAIT: if mem_rvalid=1, capture mem_rdata, err=0, go to RESP. Otherwise the counter increments.
  - When counter==TIMEOUT-1 with no rvalid: data=0, err=1, go to RESP.
  - mem_rvalid seen in any state other than WAIT is ignored, including a late response after a timeout.
- RESP: resp_valid=1 only for the latched master, with data/err held stable. When resp_ready=1, go to IDLE.
  - Back-to-back is allowed: a new request can be accepted on the IDLE cycle immediately after RESP.
- Latency (zero-wait memory, ready held high):
  - Read: accept at cycle 0; ISSUE at cycle 1; WAIT at cycle 2 samples rvalid; RESP at cycle 3. Total 4 cycles per transaction.
  - Write: accept, ISSUE, RESP. Total 3 cycles.
- Request inputs are ignored outside IDLE, and both req_ready are 0 there. A master may change or drop a request while not granted.
- Unused latched fields for IFU transactions: wdata=0, wmask=0.
- Reset mid-transaction returns to IDLE immediately with strobes 0; the in-flight transaction is dropped and gets no response.

Test Plan:
- IFU read addr=0x8000_0000, memory returns 0x1122334455667788 -> mem_ren high exactly 1 cycle; if_resp_valid 3 cycles after accept with that data, err=0.
- LSU write addr=0x8000_0010, wdata=0xDEADBEEF, wmask=0x0F -> mem_wen 1 cycle with those values; ls_resp_valid 2 cycles after accept, data=0, err=0.
- Both masters valid continuously for 4 transactions after reset -> grant order IFU, LSU, IFU, LSU; never two transactions in flight.
- IFU read with mem_rvalid held 0 (TIMEOUT=16) -> if_resp_valid after 16 WAIT cycles, err=1, data=0. A rvalid pulse injected afterwards is ignored; the next read returns correct data.
- LSU read with ls_resp_ready held 0 for 5 cycles -> ls_resp_valid/data stable for all 5 cycles; IFU request held pending, if_req_ready=0 until the IDLE cycle after the LSU response is taken.
- Assert reset during WAIT -> all strobes and resp_valid go to 0 asynchronously. After release, state is IDLE and the first simultaneous request is granted to IFU.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter and sequencer. The IFU issues reads only and the LSU
// issues reads and writes. One transaction is in flight at a time, masters are
// granted round-robin, and a read whose data never arrives ends in an error response.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 33,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset,
  // IFU channel
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_resp_valid,
  input  logic                if_resp_ready,
  output logic [DATA_W-1:0]   if_resp_data,
  output logic                if_resp_err,
  // LSU channel
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic                ls_req_wen,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_resp_valid,
  input  logic                ls_resp_ready,
  output logic [DATA_W-1:0]   ls_resp_data,
  output logic                ls_resp_err,
  // Memory port
  output logic                mem_ren,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic MIfu = 1'b0;
  localparam logic MLsu = 1'b1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              r_state;
  logic                r_rr_last;
  logic [CntW-1:0]     r_cnt;
  logic                r_mid;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wmask;
  logic [DATA_W-1:0]   r_resp_data;
  logic                r_resp_err;

  logic w_gnt_if, w_gnt_ls, w_if_hs, w_ls_hs, w_resp_ready, w_in_resp;

  // Grant: sole requester wins; on contention the master not served last wins.
  always_comb begin
    w_gnt_if     = if_req_valid & (~ls_req_valid | (r_rr_last == MLsu));
    w_gnt_ls     = ls_req_valid & (~if_req_valid | (r_rr_last == MIfu));
    if_req_ready = (r_state == StIdle) & w_gnt_if;
    ls_req_ready = (r_state == StIdle) & w_gnt_ls;
    w_if_hs      = if_req_ready & if_req_valid;
    w_ls_hs      = ls_req_ready & ls_req_valid;
    w_resp_ready = (r_mid == MLsu) ? ls_resp_ready : if_resp_ready;
  end

  // Memory strobes only in ISSUE; response channel only to the latched master.
  always_comb begin
    w_in_resp     = (r_state == StResp);
    mem_ren       = (r_state == StIssue) & ~r_wen;
    mem_wen       = (r_state == StIssue) & r_wen;
    mem_addr      = r_addr;
    mem_wdata     = r_wdata;
    mem_wmask     = r_wmask;
    if_resp_valid = w_in_resp & (r_mid == MIfu);
    ls_resp_valid = w_in_resp & (r_mid == MLsu);
    if_resp_data  = if_resp_valid ? r_resp_data : '0;
    ls_resp_data  = ls_resp_valid ? r_resp_data : '0;
    if_resp_err   = if_resp_valid & r_resp_err;
    ls_resp_err   = ls_resp_valid & r_resp_err;
  end

  // Transaction sequencer: accept, issue, wait for read data or timeout, respond.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_rr_last   <= MLsu;
      r_cnt       <= '0;
      r_mid       <= MIfu;
      r_addr      <= '0;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_if_hs) begin
            r_mid     <= MIfu;
            r_addr    <= if_req_addr;
            r_wen     <= 1'b0;
            r_wdata   <= '0;
            r_wmask   <= '0;
            r_rr_last <= MIfu;
            r_state   <= StIssue;
          end else if (w_ls_hs) begin
            r_mid     <= MLsu;
            r_addr    <= ls_req_addr;
            r_wen     <= ls_req_wen;
            r_wdata   <= ls_req_wdata;
            r_wmask   <= ls_req_wmask;
            r_rr_last <= MLsu;
            r_state   <= StIssue;
          end
        end
        StIssue: begin
          if (r_wen) begin
            // Writes complete at the memory edge; acknowledge with zero data.
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
            r_state     <= StResp;
          end else begin
            r_cnt   <= '0;
            r_state <= StWait;
          end
        end
        StWait: begin
          if (mem_rvalid) begin
            r_resp_data <= mem_rdata;
            r_resp_err  <= 1'b0;
            r_state     <= StResp;
          end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b1;
            r_state     <= StResp;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StResp: begin
          if (w_resp_ready) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 1-cycle registered read memory.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W  = 33;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned TIMEOUT = 16;

  logic                clock;
  logic                reset;
  logic                if_req_valid, if_req_ready, if_resp_valid, if_resp_ready, if_resp_err;
  logic [ADDR_W-1:0]   if_req_addr;
  logic [DATA_W-1:0]   if_resp_data;
  logic                ls_req_valid, ls_req_ready, ls_req_wen;
  logic                ls_resp_valid, ls_resp_ready, ls_resp_err;
  logic [ADDR_W-1:0]   ls_req_addr;
  logic [DATA_W-1:0]   ls_req_wdata, ls_resp_data;
  logic [DATA_W/8-1:0] ls_req_wmask;
  logic                mem_ren, mem_wen, mem_rvalid;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata, mem_rdata;
  logic [DATA_W/8-1:0] mem_wmask;

  // Memory model controls
  logic                rvalid_en;
  logic [DATA_W-1:0]   tb_rdata;
  logic                inj_rvalid;
  logic [DATA_W-1:0]   inj_rdata;
  logic                m_rvalid_q;
  logic [DATA_W-1:0]   m_rdata_q;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_resp_valid (if_resp_valid),
    .if_resp_ready (if_resp_ready),
    .if_resp_data  (if_resp_data),
    .if_resp_err   (if_resp_err),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_req_wen    (ls_req_wen),
    .ls_req_addr   (ls_req_addr),
    .ls_req_wdata  (ls_req_wdata),
    .ls_req_wmask  (ls_req_wmask),
    .ls_resp_valid (ls_resp_valid),
    .ls_resp_ready (ls_resp_ready),
    .ls_resp_data  (ls_resp_data),
    .ls_resp_err   (ls_resp_err),
    .mem_ren       (mem_ren),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Registered read memory: rvalid one cycle after mem_ren, optionally suppressed.
  always @(posedge clock) begin
    m_rvalid_q <= mem_ren & rvalid_en;
    m_rdata_q  <= mem_ren ? tb_rdata : '0;
  end
  assign mem_rvalid = m_rvalid_q | inj_rvalid;
  assign mem_rdata  = inj_rvalid ? inj_rdata : m_rdata_q;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    total++; if (mem_ren !== 1'b0) begin bad++; $display("FAIL rst_ren got=%b want=0", mem_ren); end
    total++; if (mem_wen !== 1'b0) begin bad++; $display("FAIL rst_wen got=%b want=0", mem_wen); end
    total++; if (if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_resp got=%b%b want=00", if_resp_valid, ls_resp_valid);
    end
    total++; if (if_req_ready !== 1'b0 || ls_req_ready !== 1'b0) begin
      bad++; $display("FAIL rst_ready_idle got=%b%b want=00", if_req_ready, ls_req_ready);
    end
    // Under reset the IDLE grant rule still applies, with rr_last = LSU.
    if_req_valid = 1'b1; ls_req_valid = 1'b1; #1;
    total++; if (if_req_ready !== 1'b1 || ls_req_ready !== 1'b0) begin
      bad++; $display("FAIL rst_grant got=%b%b want=10", if_req_ready, ls_req_ready);
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_ifu_read();
    if_req_addr = 33'h0_8000_0000; tb_rdata = 64'h1122_3344_5566_7788;
    if_req_valid = 1'b1; #1;
    total++; if (if_req_ready !== 1'b1) begin bad++; $display("FAIL ifr_accept got=%b want=1", if_req_ready); end
    tick(); if_req_valid = 1'b0; #1;
    total++; if (mem_ren !== 1'b1 || mem_wen !== 1'b0) begin
      bad++; $display("FAIL ifr_issue ren/wen got=%b%b want=10", mem_ren, mem_wen);
    end
    total++; if (mem_addr !== 33'h0_8000_0000) begin bad++; $display("FAIL ifr_addr got=%h want=080000000", mem_addr); end
    total++; if (mem_wmask !== 8'h00) begin bad++; $display("FAIL ifr_wmask got=%h want=00", mem_wmask); end
    tick();
    total++; if (mem_ren !== 1'b0 || if_resp_valid !== 1'b0) begin
      bad++; $display("FAIL ifr_wait ren/rv got=%b%b want=00", mem_ren, if_resp_valid);
    end
    tick();
    total++; if (if_resp_valid !== 1'b1 || if_resp_data !== 64'h1122_3344_5566_7788 || if_resp_err !== 1'b0) begin
      bad++; $display("FAIL ifr_resp v/data/err got=%b/%h/%b want=1/1122334455667788/0",
                      if_resp_valid, if_resp_data, if_resp_err);
    end
    total++; if (ls_resp_valid !== 1'b0) begin bad++; $display("FAIL ifr_ls_quiet got=%b want=0", ls_resp_valid); end
    tick();
    total++; if (if_resp_valid !== 1'b0) begin bad++; $display("FAIL ifr_done got=%b want=0", if_resp_valid); end
  endtask

  task automatic test_lsu_write();
    ls_req_addr = 33'h0_8000_0010; ls_req_wdata = 64'h0000_0000_DEAD_BEEF;
    ls_req_wmask = 8'h0F; ls_req_wen = 1'b1; ls_req_valid = 1'b1; #1;
    total++; if (ls_req_ready !== 1'b1) begin bad++; $display("FAIL lsw_accept got=%b want=1", ls_req_ready); end
    tick(); ls_req_valid = 1'b0; ls_req_wen = 1'b0; #1;
    total++; if (mem_wen !== 1'b1 || mem_ren !== 1'b0) begin
      bad++; $display("FAIL lsw_issue wen/ren got=%b%b want=10", mem_wen, mem_ren);
    end
    total++; if (mem_addr !== 33'h0_8000_0010 || mem_wdata !== 64'hDEAD_BEEF || mem_wmask !== 8'h0F) begin
      bad++; $display("FAIL lsw_fields got=%h/%h/%h want=080000010/00000000deadbeef/0f",
                      mem_addr, mem_wdata, mem_wmask);
    end
    tick();
    total++; if (ls_resp_valid !== 1'b1 || ls_resp_data !== 64'h0 || ls_resp_err !== 1'b0 || mem_wen !== 1'b0) begin
      bad++; $display("FAIL lsw_resp v/data/err/wen got=%b/%h/%b/%b want=1/0/0/0",
                      ls_resp_valid, ls_resp_data, ls_resp_err, mem_wen);
    end
    tick();
    total++; if (ls_resp_valid !== 1'b0) begin bad++; $display("FAIL lsw_done got=%b want=0", ls_resp_valid); end
  endtask

  task automatic test_back_to_back();
    int ngrant;
    int gcyc[4];
    logic gm[4];
    ngrant = 0;
    reset = 1'b0; #1; tick(); reset = 1'b1; tick();
    tb_rdata = 64'h5555_AAAA_5555_AAAA;
    if_req_addr = 33'h0_8000_0100; ls_req_addr = 33'h0_8000_0200; ls_req_wen = 1'b0;
    if_req_valid = 1'b1; ls_req_valid = 1'b1; #1;
    for (int c = 0; c < 40 && ngrant < 4; c++) begin
      total++; if (if_req_ready && ls_req_ready) begin
        bad++; $display("FAIL rr_both_ready cycle=%0d got=11 want=not11", c);
      end
      if (if_req_ready || ls_req_ready) begin
        gm[ngrant] = ls_req_ready; gcyc[ngrant] = c; ngrant++;
      end
      if (ngrant < 4) tick();
    end
    tick();
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    repeat (4) tick();
    total++; if (ngrant != 4) begin bad++; $display("FAIL rr_grants got=%0d want=4", ngrant); end
    for (int i = 0; i < 4 && i < ngrant; i++) begin
      total++; if (gm[i] !== logic'(i % 2)) begin
        bad++; $display("FAIL rr_order idx=%0d got=%b want=%b (0=IFU)", i, gm[i], i % 2);
      end
      total++; if (gcyc[i] != 4 * i) begin
        bad++; $display("FAIL rr_cycle idx=%0d got=%0d want=%0d", i, gcyc[i], 4 * i);
      end
    end
  endtask

  task automatic test_timeout();
    int cyc;
    rvalid_en = 1'b0;
    if_req_addr = 33'h0_8000_0040; if_req_valid = 1'b1; #1;
    tick(); if_req_valid = 1'b0;
    cyc = 1;
    while (!if_resp_valid && cyc < 40) begin tick(); cyc++; end
    total++; if (cyc != 18) begin bad++; $display("FAIL to_latency got=%0d want=18", cyc); end
    total++; if (if_resp_valid !== 1'b1 || if_resp_err !== 1'b1 || if_resp_data !== 64'h0) begin
      bad++; $display("FAIL to_resp v/err/data got=%b/%b/%h want=1/1/0",
                      if_resp_valid, if_resp_err, if_resp_data);
    end
    tick();
    // Late response after the timeout must be ignored.
    inj_rdata = 64'hBAD0_BAD0_BAD0_BAD0; inj_rvalid = 1'b1; #1;
    tick(); inj_rvalid = 1'b0; #1;
    total++; if (if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0) begin
      bad++; $display("FAIL to_late got=%b%b want=00", if_resp_valid, ls_resp_valid);
    end
    rvalid_en = 1'b1; tb_rdata = 64'hCAFE_F00D_0BAD_BEEF;
    if_req_valid = 1'b1; #1;
    tick(); if_req_valid = 1'b0;
    tick(); tick();
    total++; if (if_resp_valid !== 1'b1 || if_resp_data !== 64'hCAFE_F00D_0BAD_BEEF || if_resp_err !== 1'b0) begin
      bad++; $display("FAIL to_next v/data/err got=%b/%h/%b want=1/cafef00d0badbeef/0",
                      if_resp_valid, if_resp_data, if_resp_err);
    end
    tick();
  endtask

  task automatic test_resp_backpressure();
    tb_rdata = 64'h0123_4567_89AB_CDEF;
    ls_resp_ready = 1'b0; ls_req_wen = 1'b0; ls_req_addr = 33'h0_8000_0020;
    ls_req_valid = 1'b1; #1;
    total++; if (ls_req_ready !== 1'b1) begin bad++; $display("FAIL bp_accept got=%b want=1", ls_req_ready); end
    tick(); ls_req_valid = 1'b0; if_req_valid = 1'b1; #1;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      total++; if (ls_resp_valid !== 1'b1 || ls_resp_data !== 64'h0123_4567_89AB_CDEF || ls_resp_err !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d v/data/err got=%b/%h/%b want=1/0123456789abcdef/0",
                        i, ls_resp_valid, ls_resp_data, ls_resp_err);
      end
      total++; if (if_req_ready !== 1'b0) begin bad++; $display("FAIL bp_if_blocked cyc=%0d got=1 want=0", i); end
      tick();
    end
    ls_resp_ready = 1'b1; #1;
    total++; if (if_req_ready !== 1'b0) begin bad++; $display("FAIL bp_if_at_take got=1 want=0"); end
    tick();
    total++; if (if_req_ready !== 1'b1 || ls_resp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_if_after got=%b/%b want=1/0", if_req_ready, ls_resp_valid);
    end
    tick(); if_req_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    // Reset during ISSUE drops the read strobe immediately.
    rvalid_en = 1'b0; if_req_addr = 33'h0_8000_0080; if_req_valid = 1'b1; #1;
    tick(); if_req_valid = 1'b0; #1;
    total++; if (mem_ren !== 1'b1) begin bad++; $display("FAIL rm_issue_ren got=%b want=1", mem_ren); end
    reset = 1'b0; #1;
    total++; if (mem_ren !== 1'b0) begin bad++; $display("FAIL rm_issue_async got=%b want=0", mem_ren); end
    tick(); reset = 1'b1; tick();
    // Reset during WAIT, with rr_last = IFU beforehand.
    if_req_valid = 1'b1; #1;
    tick(); if_req_valid = 1'b0;
    tick();
    reset = 1'b0; #1;
    total++; if (mem_ren !== 1'b0 || mem_wen !== 1'b0 || if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0) begin
      bad++; $display("FAIL rm_wait_async got=%b%b%b%b want=0000",
                      mem_ren, mem_wen, if_resp_valid, ls_resp_valid);
    end
    tick(); reset = 1'b1; tick();
    if_req_valid = 1'b1; ls_req_valid = 1'b1; #1;
    total++; if (if_req_ready !== 1'b1 || ls_req_ready !== 1'b0) begin
      bad++; $display("FAIL rm_first_grant got=%b%b want=10", if_req_ready, ls_req_ready);
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    // Reset during RESP clears the pending response at once.
    rvalid_en = 1'b1; ls_resp_ready = 1'b0; ls_req_addr = 33'h0_8000_0030; ls_req_valid = 1'b1; #1;
    tick(); ls_req_valid = 1'b0;
    tick(); tick(); #1;
    total++; if (ls_resp_valid !== 1'b1) begin bad++; $display("FAIL rm_resp_pre got=%b want=1", ls_resp_valid); end
    reset = 1'b0; #1;
    total++; if (ls_resp_valid !== 1'b0) begin bad++; $display("FAIL rm_resp_async got=%b want=0", ls_resp_valid); end
    tick(); reset = 1'b1; ls_resp_ready = 1'b1; tick();
    total++; if (ls_resp_valid !== 1'b0 || if_req_ready !== 1'b0) begin
      bad++; $display("FAIL rm_idle_after got=%b%b want=00", ls_resp_valid, if_req_ready);
    end
  endtask

  initial begin
    reset = 1'b0;
    if_req_valid = 1'b0; if_req_addr = '0; if_resp_ready = 1'b1;
    ls_req_valid = 1'b0; ls_req_wen = 1'b0; ls_req_addr = '0;
    ls_req_wdata = '0; ls_req_wmask = '0; ls_resp_ready = 1'b1;
    rvalid_en = 1'b1; tb_rdata = '0; inj_rvalid = 1'b0; inj_rdata = '0;
    @(negedge clock);
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_back_to_back();
    test_timeout();
    test_resp_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
